alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Registered, parametrised-width ALU for the MIPS datapath with a valid/ready handshake on both sides.
//  Single-cycle ops: ADD, SUB, AND, OR, XOR, SLT, SLL. Optional iterative signed multiply.
//  Returns a registered result plus zero/sign/overflow/carry flags.
//  Sits between the register-file read stage and writeback; holds its result until writeback takes it.
// PARAMETERS
//  WIDTH  8  operand/result width; must be a power of two, >= 4
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      operands/func valid
//  in_ready   out  1      block accepts operands this cycle
//  a          in   WIDTH  operand A, signed two's complement
//  b          in   WIDTH  operand B, signed; low $clog2(WIDTH) bits = shift amount for SLL
//  func       in   3      0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 MUL
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes result this cycle
//  result     out  WIDTH  registered result
//  is_zero    out  1      result == 0
//  is_sign    out  1      result[WIDTH-1]
//  is_ovf     out  1      signed overflow (see below)
//  is_carry   out  1      ADD carry-out / SUB borrow, else 0
//  busy       out  1      multiply in progress
// BEHAVIOUR
//  - Reset: state IDLE; result = 0; all flags 0; out_valid = 0; busy = 0; in_ready = 1 (from the cycle after reset deasserts).
//  - Reset mid-multiply aborts the multiply; no result is emitted.
//  - FSM states:
//      IDLE: in_ready = 1.
//      BUSY: in_ready = 0; busy = 1.
//      DONE: out_valid = 1; in_ready = out_ready.
//  - Accept = in_valid & in_ready, sampled at the clock edge.
//  - Single-cycle op accepted in cycle N: result/flags registered at edge N -> out_valid = 1 in cycle N+1; state DONE.
//  - DONE with out_ready = 1 and no accept: go to IDLE; out_valid = 0 next cycle.
//  - DONE with out_ready = 1 and an accept (back-to-back): new single-cycle result overwrites the old one on the same edge; out_valid stays 1.
//  - DONE with out_ready = 0: result and flags hold, stable; in_ready = 0.
//  - in_valid while in_ready = 0 is ignored; the source must hold its data.
//  - Arithmetic (mod 2^WIDTH):
//      ADD: is_ovf = (a[MSB] == b[MSB]) & (r[MSB] != a[MSB]); is_carry = unsigned carry-out.
//      SUB: is_ovf = (a[MSB] != b[MSB]) & (r[MSB] != a[MSB]); is_carry = (a < b) unsigned.
//      SLT: r = {0..., (a < b) signed}.
//      SLL: r = a << b[$clog2(WIDTH)-1:0].
//      Logic ops and SLT/SLL: is_ovf = 0, is_carry = 0.
//  - is_zero and is_sign are always derived from the registered result.
// CONFIGURATION
//  ALU_MUL_EN defined:
//    - func 7 = signed multiply by shift-add: BUSY for exactly WIDTH cycles, then DONE.
//    - Accepted in cycle N -> out_valid in cycle N+WIDTH+1.
//    - result = low WIDTH bits of the 2*WIDTH-bit signed product.
//    - is_ovf = 1 when the product does not fit in signed WIDTH bits; is_carry = 0.
//  ALU_MUL_EN undefined:
//    - No multiplier logic and no BUSY state; busy is tied to 0.
//    - func 7 completes in one cycle with result = 0, is_zero = 1, other flags 0.
// TESTING (WIDTH = 8)
//  - ADD a=0x7F b=0x01, out_ready=1 -> next cycle out_valid=1, result=0x80, is_ovf=1, is_sign=1, is_carry=0.
//  - SUB a=0x00 b=0x01 -> result=0xFF, is_carry=1, is_ovf=0.
//    SUB a=0x05 b=0x05 -> result=0x00, is_zero=1.
//  - ADD 1+2 with out_ready=0 for 3 cycles -> result=0x03 held stable, in_ready=0;
//    then out_ready=1 with SLL a=0x01 b=0x0B -> next cycle result=0x08, out_valid never drops.
//  - SLT a=0xFE b=0x01 -> result=0x01.
//    AND a=0xF0 b=0x3C -> 0x30. OR -> 0xFC. XOR -> 0xCC.
//  - ALU_MUL_EN: MUL a=0xFD b=0x05 -> busy 8 cycles, then result=0xF1, is_ovf=0.
//    MUL a=0x40 b=0x04 -> result=0x00, is_ovf=1, is_zero=1.
//  - Reset asserted in 3rd busy cycle -> next cycle out_valid=0, busy=0, result=0, in_ready=1 once reset deasserts.
//    Without ALU_MUL_EN: func 7 -> result=0, is_zero=1 in one cycle.

Source files
------------

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: valid/ready toward the register-file
// read stage on one side and toward writeback on the other.
interface alu_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       func;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             is_zero;
    logic             is_sign;
    logic             is_ovf;
    logic             is_carry;
    logic             busy;

    modport master (
        output in_valid, a, b, func, out_ready,
        input  in_ready, out_valid, result, is_zero, is_sign, is_ovf, is_carry, busy
    );

    modport slave (
        input  in_valid, a, b, func, out_ready,
        output in_ready, out_valid, result, is_zero, is_sign, is_ovf, is_carry, busy
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered MIPS-datapath ALU with valid/ready on both sides and result hold.
// Define ALU_MUL_EN to add an iterative signed shift-add multiplier on func 7.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] F_ADD = 3'd0;
    localparam logic [2:0] F_SUB = 3'd1;
    localparam logic [2:0] F_AND = 3'd2;
    localparam logic [2:0] F_OR  = 3'd3;
    localparam logic [2:0] F_XOR = 3'd4;
    localparam logic [2:0] F_SLT = 3'd5;
    localparam logic [2:0] F_SLL = 3'd6;

`ifdef ALU_MUL_EN
    localparam logic [2:0] F_MUL = 3'd7;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
    typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif

    state_t           state_reg, state_next, accept_state;
    logic [WIDTH-1:0] result_reg;
    logic             is_zero_reg, is_sign_reg, is_ovf_reg, is_carry_reg;
    logic             in_ready_int, accept, load_alu;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf, alu_carry;
    logic [WIDTH:0]   add_full, sub_full;

    // Single-cycle datapath; bit WIDTH of the extended sums is carry-out / borrow.
    assign add_full = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_full = {1'b0, bus.a} - {1'b0, bus.b};

    always_comb begin
        alu_res   = '0;
        alu_ovf   = 1'b0;
        alu_carry = 1'b0;
        case (bus.func)
            F_ADD: begin
                alu_res   = add_full[MSB:0];
                alu_ovf   = (bus.a[MSB] == bus.b[MSB]) & (add_full[MSB] != bus.a[MSB]);
                alu_carry = add_full[WIDTH];
            end
            F_SUB: begin
                alu_res   = sub_full[MSB:0];
                alu_ovf   = (bus.a[MSB] != bus.b[MSB]) & (sub_full[MSB] != bus.a[MSB]);
                alu_carry = sub_full[WIDTH];
            end
            F_AND:   alu_res = bus.a & bus.b;
            F_OR:    alu_res = bus.a | bus.b;
            F_XOR:   alu_res = bus.a ^ bus.b;
            F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            F_SLL:   alu_res = bus.a << bus.b[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        in_ready_int = 1'b0;
        case (state_reg)
            IDLE:    in_ready_int = 1'b1;
            DONE:    in_ready_int = bus.out_ready;
            default: in_ready_int = 1'b0;
        endcase
    end

    assign bus.in_ready = in_ready_int & ~reset;
    assign accept       = bus.in_valid & bus.in_ready;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] acc_reg, mcand_reg, acc_next;
    logic [WIDTH-1:0]   mplier_reg;
    logic [SHW-1:0]     count_reg;
    logic               start_mul, last_iter, mul_ovf;

    assign start_mul = accept & (bus.func == F_MUL);
    assign load_alu  = accept & ~start_mul;
    assign last_iter = (state_reg == BUSY) && (count_reg == SHW'(WIDTH - 1));
    assign accept_state = start_mul ? BUSY : DONE;

    // The multiplier MSB carries weight -2^(WIDTH-1), so its partial product is subtracted.
    always_comb begin
        acc_next = acc_reg;
        if (mplier_reg[0]) begin
            acc_next = last_iter ? (acc_reg - mcand_reg) : (acc_reg + mcand_reg);
        end
    end

    assign mul_ovf = ~((&acc_next[2*WIDTH-1:MSB]) | ~(|acc_next[2*WIDTH-1:MSB]));

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
        end else if (start_mul) begin
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{bus.a[MSB]}}, bus.a};
            mplier_reg <= bus.b;
            count_reg  <= '0;
        end else if (state_reg == BUSY) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg + 1'b1;
        end
    end

    assign bus.busy = (state_reg == BUSY);
`else
    assign load_alu     = accept;
    assign accept_state = DONE;
    assign bus.busy     = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = accept_state;
`ifdef ALU_MUL_EN
            BUSY: if (last_iter) state_next = DONE;
`endif
            DONE: begin
                if (accept) begin
                    state_next = accept_state;
                end else if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result and flags only change on a load, so they stay stable while writeback stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            result_reg   <= '0;
            is_zero_reg  <= 1'b0;
            is_sign_reg  <= 1'b0;
            is_ovf_reg   <= 1'b0;
            is_carry_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load_alu) begin
                result_reg   <= alu_res;
                is_zero_reg  <= (alu_res == '0);
                is_sign_reg  <= alu_res[MSB];
                is_ovf_reg   <= alu_ovf;
                is_carry_reg <= alu_carry;
            end
`ifdef ALU_MUL_EN
            else if (last_iter) begin
                result_reg   <= acc_next[MSB:0];
                is_zero_reg  <= (acc_next[MSB:0] == '0);
                is_sign_reg  <= acc_next[MSB];
                is_ovf_reg   <= mul_ovf;
                is_carry_reg <= 1'b0;
            end
`endif
        end
    end

    assign bus.out_valid = (state_reg == DONE);
    assign bus.result    = result_reg;
    assign bus.is_zero   = is_zero_reg;
    assign bus.is_sign   = is_sign_reg;
    assign bus.is_ovf    = is_ovf_reg;
    assign bus.is_carry  = is_carry_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH = 8; multiplier scenarios run only when ALU_MUL_EN is defined.
module tb_alu_seq;
    logic clk;
    logic reset;
    int   vec_count;
    int   miss_count;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [7:0] av, input logic [7:0] bv);
        bus.in_valid = 1'b1;
        bus.func     = f;
        bus.a        = av;
        bus.b        = bv;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.func      = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        vec_count++; if (bus.out_valid !== 1'b0) begin miss_count++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        vec_count++; if (bus.busy !== 1'b0) begin miss_count++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        vec_count++; if (bus.result !== 8'h00) begin miss_count++; $display("FAIL reset_result got %h exp 00", bus.result); end
        vec_count++; if ({bus.is_zero, bus.is_sign, bus.is_ovf, bus.is_carry} !== 4'b0000) begin
            miss_count++; $display("FAIL reset_flags got %b exp 0000", {bus.is_zero, bus.is_sign, bus.is_ovf, bus.is_carry}); end
        reset = 1'b0;
        tick();
        vec_count++; if (bus.in_ready !== 1'b1) begin miss_count++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_add_ovf();
        bus.out_ready = 1'b1;
        drive(3'd0, 8'h7F, 8'h01);
        tick();
        bus.in_valid = 1'b0;
        vec_count++; if (bus.out_valid !== 1'b1) begin miss_count++; $display("FAIL add_out_valid got %b exp 1", bus.out_valid); end
        vec_count++; if (bus.result !== 8'h80) begin miss_count++; $display("FAIL add_result got %h exp 80", bus.result); end
        vec_count++; if ({bus.is_ovf, bus.is_sign, bus.is_carry, bus.is_zero} !== 4'b1100) begin
            miss_count++; $display("FAIL add_flags ovf/sign/carry/zero got %b exp 1100", {bus.is_ovf, bus.is_sign, bus.is_carry, bus.is_zero}); end
        tick();
        vec_count++; if (bus.out_valid !== 1'b0) begin miss_count++; $display("FAIL add_consumed got %b exp 0", bus.out_valid); end
        $display("ADD 7F+01 -> %h", bus.result);
    endtask

    task automatic test_sub();
        bus.out_ready = 1'b1;
        drive(3'd1, 8'h00, 8'h01);
        tick();
        bus.in_valid = 1'b0;
        vec_count++; if (bus.result !== 8'hFF) begin miss_count++; $display("FAIL sub_borrow_result got %h exp FF", bus.result); end
        vec_count++; if ({bus.is_carry, bus.is_ovf, bus.is_sign} !== 3'b101) begin
            miss_count++; $display("FAIL sub_borrow_flags carry/ovf/sign got %b exp 101", {bus.is_carry, bus.is_ovf, bus.is_sign}); end
        tick();
        drive(3'd1, 8'h05, 8'h05);
        tick();
        bus.in_valid = 1'b0;
        vec_count++; if (bus.result !== 8'h00) begin miss_count++; $display("FAIL sub_equal_result got %h exp 00", bus.result); end
        vec_count++; if ({bus.is_zero, bus.is_carry, bus.is_ovf} !== 3'b100) begin
            miss_count++; $display("FAIL sub_equal_flags zero/carry/ovf got %b exp 100", {bus.is_zero, bus.is_carry, bus.is_ovf}); end
        tick();
        $display("SUB vectors done");
    endtask

    task automatic test_hold();
        bus.out_ready = 1'b0;
        drive(3'd0, 8'h01, 8'h02);
        tick();
        // Source presents the next op and holds it while writeback stalls.
        drive(3'd6, 8'h01, 8'h0B);
        for (int i = 0; i < 3; i++) begin
            vec_count++; if (bus.result !== 8'h03) begin miss_count++; $display("FAIL hold_result cyc %0d got %h exp 03", i, bus.result); end
            vec_count++; if (bus.in_ready !== 1'b0) begin miss_count++; $display("FAIL hold_in_ready cyc %0d got %b exp 0", i, bus.in_ready); end
            vec_count++; if (bus.out_valid !== 1'b1) begin miss_count++; $display("FAIL hold_out_valid cyc %0d got %b exp 1", i, bus.out_valid); end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        vec_count++; if (bus.in_ready !== 1'b1) begin miss_count++; $display("FAIL hold_release_in_ready got %b exp 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        vec_count++; if (bus.out_valid !== 1'b1) begin miss_count++; $display("FAIL sll_out_valid got %b exp 1", bus.out_valid); end
        vec_count++; if (bus.result !== 8'h08) begin miss_count++; $display("FAIL sll_result got %h exp 08", bus.result); end
        tick();
        $display("hold then SLL 01<<3 done");
    endtask

    task automatic test_back_to_back();
        logic [2:0] f  [6];
        logic [7:0] av [6];
        logic [7:0] bv [6];
        logic [7:0] er [6];
        logic [3:0] ef [6];
        f[0] = 3'd5; av[0] = 8'hFE; bv[0] = 8'h01; er[0] = 8'h01; ef[0] = 4'b0000;
        f[1] = 3'd2; av[1] = 8'hF0; bv[1] = 8'h3C; er[1] = 8'h30; ef[1] = 4'b0000;
        f[2] = 3'd3; av[2] = 8'hF0; bv[2] = 8'h3C; er[2] = 8'hFC; ef[2] = 4'b0100;
        f[3] = 3'd4; av[3] = 8'hF0; bv[3] = 8'h3C; er[3] = 8'hCC; ef[3] = 4'b0100;
        f[4] = 3'd0; av[4] = 8'hFF; bv[4] = 8'h01; er[4] = 8'h00; ef[4] = 4'b1001;
        f[5] = 3'd5; av[5] = 8'h01; bv[5] = 8'hFE; er[5] = 8'h00; ef[5] = 4'b1000;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(f[i], av[i], bv[i]);
            tick();
            vec_count++; if (bus.out_valid !== 1'b1) begin miss_count++; $display("FAIL b2b_out_valid op %0d got %b exp 1", i, bus.out_valid); end
            vec_count++; if (bus.result !== er[i]) begin miss_count++; $display("FAIL b2b_result op %0d got %h exp %h", i, bus.result, er[i]); end
            vec_count++; if ({bus.is_zero, bus.is_sign, bus.is_ovf, bus.is_carry} !== ef[i]) begin
                miss_count++; $display("FAIL b2b_flags op %0d zsoc got %b exp %b", i, {bus.is_zero, bus.is_sign, bus.is_ovf, bus.is_carry}, ef[i]); end
            $display("op func=%0d a=%h b=%h -> %h", f[i], av[i], bv[i], bus.result);
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

`ifdef ALU_MUL_EN
    task automatic run_mul(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] er, input logic eo);
        bus.out_ready = 1'b1;
        drive(3'd7, av, bv);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vec_count++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
                miss_count++; $display("FAIL mul_busy cyc %0d busy/out_valid/in_ready got %b%b%b exp 100", i, bus.busy, bus.out_valid, bus.in_ready); end
            tick();
        end
        vec_count++; if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0) begin
            miss_count++; $display("FAIL mul_done out_valid/busy got %b%b exp 10", bus.out_valid, bus.busy); end
        vec_count++; if (bus.result !== er) begin miss_count++; $display("FAIL mul_result %h*%h got %h exp %h", av, bv, bus.result, er); end
        vec_count++; if (bus.is_ovf !== eo || bus.is_carry !== 1'b0 || bus.is_zero !== (er == 8'h00)) begin
            miss_count++; $display("FAIL mul_flags ovf/carry/zero got %b%b%b exp %b0%b", bus.is_ovf, bus.is_carry, bus.is_zero, eo, (er == 8'h00)); end
        $display("MUL %h*%h -> %h ovf=%b", av, bv, bus.result, bus.is_ovf);
        tick();
    endtask

    task automatic test_mul();
        run_mul(8'h40, 8'h04, 8'h00, 1'b1);
        run_mul(8'hFD, 8'h05, 8'hF1, 1'b0);
        run_mul(8'hFA, 8'hFD, 8'h12, 1'b0);
    endtask

    task automatic test_reset_mid_mul();
        bus.out_ready = 1'b1;
        drive(3'd7, 8'h03, 8'h03);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        vec_count++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            miss_count++; $display("FAIL abort_state out_valid/busy got %b%b exp 00", bus.out_valid, bus.busy); end
        vec_count++; if (bus.result !== 8'h00) begin miss_count++; $display("FAIL abort_result got %h exp 00", bus.result); end
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            vec_count++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                miss_count++; $display("FAIL abort_idle cyc %0d out_valid/in_ready got %b%b exp 01", i, bus.out_valid, bus.in_ready); end
        end
        $display("reset mid-multiply done");
    endtask
`else
    task automatic test_func7();
        bus.out_ready = 1'b1;
        drive(3'd7, 8'h12, 8'h34);
        tick();
        bus.in_valid = 1'b0;
        vec_count++; if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0) begin
            miss_count++; $display("FAIL func7_state out_valid/busy got %b%b exp 10", bus.out_valid, bus.busy); end
        vec_count++; if (bus.result !== 8'h00) begin miss_count++; $display("FAIL func7_result got %h exp 00", bus.result); end
        vec_count++; if ({bus.is_zero, bus.is_sign, bus.is_ovf, bus.is_carry} !== 4'b1000) begin
            miss_count++; $display("FAIL func7_flags zsoc got %b exp 1000", {bus.is_zero, bus.is_sign, bus.is_ovf, bus.is_carry}); end
        tick();
        $display("func 7 without multiplier -> %h", bus.result);
    endtask
`endif

    initial begin
        vec_count  = 0;
        miss_count = 0;
        test_reset();
        test_add_ovf();
        test_sub();
        test_hold();
        test_back_to_back();
`ifdef ALU_MUL_EN
        test_mul();
        test_reset_mid_mul();
`else
        test_func7();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end
endmodule
